// File: rtl/bn_backward.sv
// rtl/bn_backward.sv - batch-norm backward pass for one channel
// Accumulates dbeta/dgama over a batch, then replays buffered samples to emit dx.
module bn_backward #(
    parameter int N     = 16,
    parameter int FRAC  = 8,
    parameter int BATCH = 8,
    parameter int LOG2B = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   dy,
    input  logic signed [N-1:0]   xhat,
    input  logic signed [N-1:0]   gama,
    input  logic signed [N-1:0]   inv_std,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [N-1:0]   dx,
    output logic signed [2*N-1:0] dgama,
    output logic signed [2*N-1:0] dbeta,
    output logic                  stat_valid,
    output logic                  done
);
    localparam int SDY_W = N + LOG2B;
    localparam int SDX_W = 2 * N + LOG2B;
    localparam int W     = 64;
    localparam logic signed [W-1:0] MAX_N  = (64'sd1 <<< (N - 1)) - 64'sd1;
    localparam logic signed [W-1:0] MIN_N  = -MAX_N - 64'sd1;
    localparam logic signed [W-1:0] MAX_2N = (64'sd1 <<< (2 * N - 1)) - 64'sd1;
    localparam logic signed [W-1:0] MIN_2N = -MAX_2N - 64'sd1;

    typedef enum logic [1:0] {ACCUM, CALC, EMIT} state_t;
    state_t state;

    logic [LOG2B-1:0]        cnt, idx, nidx, sel;
    logic signed [SDY_W-1:0] sum_dy;
    logic signed [SDX_W-1:0] sum_dyx;
    logic signed [N-1:0]     mean_dy, mean_dyx, scale;
    logic signed [N-1:0]     mean_dy_c, mean_dyx_c, scale_c;
    logic signed [N-1:0]     use_mdy, use_mdyx, use_scale, dx_next;
    logic signed [2*N-1:0]   dgama_c, prod_in, gs_prod;
    logic signed [N-1:0]     buf_dy [BATCH];
    logic signed [N-1:0]     buf_xh [BATCH];
    logic                    accept, last_beat;

    function automatic logic signed [N-1:0] sat_n(input logic signed [W-1:0] v);
        if (v > MAX_N)      return MAX_N[N-1:0];
        else if (v < MIN_N) return MIN_N[N-1:0];
        else                return v[N-1:0];
    endfunction

    function automatic logic signed [2*N-1:0] sat_2n(input logic signed [W-1:0] v);
        if (v > MAX_2N)      return MAX_2N[2*N-1:0];
        else if (v < MIN_2N) return MIN_2N[2*N-1:0];
        else                 return v[2*N-1:0];
    endfunction

    function automatic logic signed [N-1:0] calc_dx(
        input logic signed [N-1:0] d,
        input logic signed [N-1:0] x,
        input logic signed [N-1:0] md,
        input logic signed [N-1:0] mdx,
        input logic signed [N-1:0] sc
    );
        logic signed [N+1:0] t;
        logic signed [W-1:0] p;
        p = (W'(x) * W'(mdx)) >>> FRAC;
        t = (N+2)'(W'(d) - W'(md) - W'(sat_n(p)));
        p = (W'(sc) * W'(t)) >>> FRAC;
        return sat_n(p);
    endfunction

    assign prod_in   = dy * xhat;
    assign gs_prod   = gama * inv_std;
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt == LOG2B'(BATCH - 1));
    assign nidx      = idx + 1'b1;

    // In CALC the first dx is built from the not-yet-registered statistics so
    // that out_valid can rise right after the CALC cycle.
    always_comb begin
        mean_dy_c  = sat_n(W'(sum_dy) >>> LOG2B);
        mean_dyx_c = sat_n(W'(sum_dyx) >>> (LOG2B + FRAC));
        scale_c    = sat_n(W'(gs_prod) >>> FRAC);
        dgama_c    = sat_2n(W'(sum_dyx) >>> FRAC);
        if (state == CALC) begin
            sel       = '0;
            use_mdy   = mean_dy_c;
            use_mdyx  = mean_dyx_c;
            use_scale = scale_c;
        end else begin
            sel       = nidx;
            use_mdy   = mean_dy;
            use_mdyx  = mean_dyx;
            use_scale = scale;
        end
        dx_next = calc_dx(buf_dy[sel], buf_xh[sel], use_mdy, use_mdyx, use_scale);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_dy[cnt] <= dy;
            buf_xh[cnt] <= xhat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ACCUM;
            cnt        <= '0;
            idx        <= '0;
            sum_dy     <= '0;
            sum_dyx    <= '0;
            mean_dy    <= '0;
            mean_dyx   <= '0;
            scale      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            dx         <= '0;
            dgama      <= '0;
            dbeta      <= '0;
            stat_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        sum_dy  <= sum_dy + SDY_W'(dy);
                        sum_dyx <= sum_dyx + SDX_W'(prod_in);
                        if (cnt == '0) stat_valid <= 1'b0;
                        if (last_beat) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= CALC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    mean_dy    <= mean_dy_c;
                    mean_dyx   <= mean_dyx_c;
                    scale      <= scale_c;
                    dbeta      <= (2*N)'(sum_dy);
                    dgama      <= dgama_c;
                    stat_valid <= 1'b1;
                    sum_dy     <= '0;
                    sum_dyx    <= '0;
                    dx         <= dx_next;
                    idx        <= '0;
                    out_valid  <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (idx == LOG2B'(BATCH - 1)) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= ACCUM;
                        end else begin
                            idx <= nidx;
                            dx  <= dx_next;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_bn_backward.sv
// tb/tb_bn_backward.sv - table-driven and randomized bench for bn_backward
module tb_bn_backward;
    localparam int N     = 16;
    localparam int FRAC  = 8;
    localparam int BATCH = 8;
    localparam int LOG2B = 3;

    typedef struct packed {
        logic [BATCH-1:0][N-1:0] dy;
        logic [BATCH-1:0][N-1:0] xh;
        logic [N-1:0]            g;
        logic [N-1:0]            inv;
        logic [BATCH-1:0][N-1:0] edx;
        logic [2*N-1:0]          edbeta;
        logic [2*N-1:0]          edgama;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, stat_valid, done;
    logic signed [N-1:0]   dy = '0, xhat = '0, gama = '0, inv_std = '0;
    logic signed [N-1:0]   dx;
    logic signed [2*N-1:0] dgama, dbeta;

    int vectors = 0, miscompares = 0, cyc = 0;
    int cur_dy [BATCH], cur_xh [BATCH], cur_g, cur_i;
    longint exp_dx [BATCH], exp_dbeta, exp_dgama;
    int bp_idx = -1, bp_cycles = 0;
    bit rand_mode = 1'b0, stat_expect = 1'b0;
    vec_t tbl [4];

    bn_backward #(.N(N), .FRAC(FRAC), .BATCH(BATCH), .LOG2B(LOG2B)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dy(dy), .xhat(xhat), .gama(gama), .inv_std(inv_std),
        .out_valid(out_valid), .out_ready(out_ready), .dx(dx),
        .dgama(dgama), .dbeta(dbeta), .stat_valid(stat_valid), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint fdiv(input longint v, input longint d);
        longint q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -hi - 1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    task automatic model();
        longint sdy = 0, sdyx = 0, mdy, mdyx, sc, t;
        for (int i = 0; i < BATCH; i++) begin
            sdy  += cur_dy[i];
            sdyx += longint'(cur_dy[i]) * cur_xh[i];
        end
        mdy       = sat(fdiv(sdy, BATCH), N);
        mdyx      = sat(fdiv(sdyx, BATCH * (1 << FRAC)), N);
        sc        = sat(fdiv(longint'(cur_g) * cur_i, 1 << FRAC), N);
        exp_dbeta = sdy;
        exp_dgama = sat(fdiv(sdyx, 1 << FRAC), 2 * N);
        for (int i = 0; i < BATCH; i++) begin
            t = cur_dy[i] - mdy - sat(fdiv(longint'(cur_xh[i]) * mdyx, 1 << FRAC), N);
            exp_dx[i] = sat(fdiv(sc * t, 1 << FRAC), N);
        end
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < BATCH; i++) begin
            cur_dy[i] = int'($signed(tbl[v].dy[i]));
            cur_xh[i] = int'($signed(tbl[v].xh[i]));
            exp_dx[i] = longint'($signed(tbl[v].edx[i]));
        end
        cur_g     = int'($signed(tbl[v].g));
        cur_i     = int'($signed(tbl[v].inv));
        exp_dbeta = longint'($signed(tbl[v].edbeta));
        exp_dgama = longint'($signed(tbl[v].edgama));
    endtask

    task automatic run_batch(input string tag, input int stop_after);
        int n, t, hold, last_cyc;
        bit seen;
        gama    = N'(cur_g);
        inv_std = N'(cur_i);
        for (int i = 0; i < BATCH; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (rand_mode) while ($urandom_range(0, 3) == 0) @(negedge clk);
            dy       = N'(cur_dy[i]);
            xhat     = N'(cur_xh[i]);
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk({tag, " in_ready timeout"}, 0, 1);
            if (i == 0) chk({tag, " stat_valid before batch"}, stat_valid, stat_expect);
            if (i == 1) chk({tag, " stat_valid after first beat"}, stat_valid, 0);
            last_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " in_ready in CALC"}, in_ready, 0);
        chk({tag, " out_valid in CALC"}, out_valid, 0);
        n = 0; t = 0; hold = 0; seen = 0;
        while (n < BATCH && t < 300) begin
            if (t > 0) @(negedge clk);
            t++;
            if (out_valid && !seen) begin
                seen = 1;
                chk({tag, " first out_valid latency"}, cyc - last_cyc, 2);
                chk({tag, " stat_valid"}, stat_valid, 1);
                chk({tag, " dbeta"}, $signed(dbeta), exp_dbeta);
                chk({tag, " dgama"}, $signed(dgama), exp_dgama);
                gama    = N'($urandom);
                inv_std = N'($urandom);
            end
            if (bp_idx == n && out_valid && hold < bp_cycles) begin
                out_ready = 1'b0;
                hold++;
            end else if (rand_mode) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid) begin
                chk($sformatf("%s dx[%0d]%s", tag, n, out_ready ? "" : " held"), $signed(dx), exp_dx[n]);
                chk($sformatf("%s done during dx[%0d]", tag, n), done, 0);
                if (!out_ready) chk({tag, " in_ready while held"}, in_ready, 0);
                if (out_ready) begin
                    n++;
                    if (n == stop_after) return;
                end
            end
        end
        if (n < BATCH) chk({tag, " dx count before timeout"}, n, BATCH);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " done pulse"}, done, 1);
        chk({tag, " out_valid after last"}, out_valid, 0);
        chk({tag, " in_ready after last"}, in_ready, 1);
        @(negedge clk);
        chk({tag, " done cleared"}, done, 0);
        stat_expect = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " in_ready"}, in_ready, 1);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " stat_valid"}, stat_valid, 0);
        chk({tag, " dgama"}, $signed(dgama), 0);
        chk({tag, " dbeta"}, $signed(dbeta), 0);
        chk({tag, " done"}, done, 0);
    endtask

    initial begin
        for (int i = 0; i < BATCH; i++) begin
            tbl[0].dy[i] = N'(256);
            tbl[0].xh[i] = '0;
            tbl[0].edx[i] = '0;
            tbl[1].dy[i] = N'((i % 2) ? -256 : 256);
            tbl[1].xh[i] = N'((i % 2) ? -256 : 256);
            tbl[1].edx[i] = '0;
            tbl[2].dy[i] = N'((i == 0) ? 256 : 0);
            tbl[2].xh[i] = '0;
            tbl[2].edx[i] = N'((i == 0) ? 448 : -64);
            tbl[3].dy[i] = N'((i == 0) ? 32767 : -32768);
            tbl[3].xh[i] = '0;
            tbl[3].edx[i] = N'((i == 0) ? 32767 : -32768);
        end
        tbl[0].g = N'(256);   tbl[0].inv = N'(256);   tbl[0].edbeta = 32'(2048);    tbl[0].edgama = '0;
        tbl[1].g = N'(256);   tbl[1].inv = N'(256);   tbl[1].edbeta = '0;           tbl[1].edgama = 32'(2048);
        tbl[2].g = N'(512);   tbl[2].inv = N'(256);   tbl[2].edbeta = 32'(256);     tbl[2].edgama = '0;
        tbl[3].g = N'(32767); tbl[3].inv = N'(32767); tbl[3].edbeta = 32'(-196609); tbl[3].edgama = '0;

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        chk("reset dx", $signed(dx), 0);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            run_batch($sformatf("vec%0d", v), -1);
        end

        load_vec(2);
        bp_idx = 1;
        bp_cycles = 3;
        run_batch("backpressure", -1);
        bp_idx = -1;

        load_vec(2);
        run_batch("abort", 3);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_state("mid-emit reset");
        @(negedge clk);
        reset = 1'b1;
        stat_expect = 1'b0;
        load_vec(0);
        run_batch("after reset", -1);

        rand_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < BATCH; i++) begin
                if (r % 2) cur_dy[i] = int'($urandom_range(0, 65535)) - 32768;
                else       cur_dy[i] = int'($urandom_range(0, 4095)) - 2048;
                cur_xh[i] = int'($urandom_range(0, 2047)) - 1024;
            end
            cur_g = int'($urandom_range(0, 1023)) - 512;
            cur_i = int'($urandom_range(0, 1023));
            model();
            run_batch($sformatf("rand%0d", r), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bn_backward.md
Name: bn_backward

Overview:
- Batch-normalization backward pass for one channel, the gradient-direction counterpart of the BN statistics/core forward path.
- Streams in BATCH pairs of (upstream gradient dy, normalized activation xhat) and accumulates dbeta = sum(dy) and dgama = sum(dy*xhat).
- Then replays its buffered samples and emits dx = gama*inv_std*(dy - mean(dy) - xhat*mean(dy*xhat)), one value per beat.
- All data is signed fixed point with FRAC fraction bits.

Parameters:
N, 16, data width of dy/xhat/gama/inv_std/dx (signed)
FRAC, 8, fraction bits of all fixed-point operands (1.0 = 2^FRAC)
BATCH, 8, samples per batch; power of two, >= 2
LOG2B, 3, log2(BATCH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
in_valid  in  1  dy/xhat beat valid
in_ready  out  1  block accepts a beat
dy  in  N  upstream gradient sample, signed
xhat  in  N  normalized activation sample, signed
gama  in  N  BN scale, signed; sampled on entry to CALC
inv_std  in  N  1/sqrt(var+eps), signed; sampled on entry to CALC
out_valid  out  1  dx valid
out_ready  in  1  downstream accepts dx
dx  out  N  input gradient, signed, saturated
dgama  out  2N  sum(dy*xhat)>>>FRAC, saturated to 2N
dbeta  out  2N  sum(dy), sign-extended
stat_valid  out  1  dgama/dbeta valid for the current batch
done  out  1  one-cycle pulse after the last dx is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to ACCUM; counters and accumulators clear.
  - Outputs: in_ready=1, out_valid=0, dx=0, dgama=0, dbeta=0, stat_valid=0, done=0.
  - A reset asserted mid-batch discards the batch entirely.
- FSM states: ACCUM, CALC, EMIT.
- ACCUM:
  - in_ready=1.
  - Each in_valid&in_ready beat writes (dy, xhat) to buffer[cnt] and updates the accumulators: sum_dy += dy (N+LOG2B bits) and sum_dyx += dy*xhat (2N+LOG2B bits, full signed product).
  - The beat with cnt==BATCH-1 moves the FSM to CALC and clears cnt.
  - stat_valid drops to 0 on the first accepted beat of a new batch.
- CALC (exactly one cycle):
  - in_ready=0.
  - Registers, in this cycle:
    - mean_dy = sat_N(sum_dy >>> LOG2B), arithmetic shift (floor).
    - mean_dyx = sat_N(sum_dyx >>> (LOG2B+FRAC)).
    - scale = sat_N((gama*inv_std) >>> FRAC).
    - dbeta = sum_dy, sign-extended to 2N.
    - dgama = sat_2N(sum_dyx >>> FRAC).
  - stat_valid=1 from the next cycle and held until the next batch's first beat.
  - Accumulators clear. FSM goes to EMIT.
- EMIT:
  - in_ready=0.
  - For buffer index i: t = dy_i - mean_dy - sat_N((xhat_i*mean_dyx) >>> FRAC), computed in N+2 bits; dx = sat_N((scale*t) >>> FRAC).
  - The dx pipeline is registered. out_valid asserts the cycle after CALC, i.e. last input beat at cycle T gives first out_valid at T+2.
  - When out_valid&out_ready: advance to the next index. Back-to-back outputs are allowed (one per cycle at full throughput).
  - When out_valid&!out_ready: dx and out_valid hold stable; no sample is skipped or duplicated.
  - Acceptance of index BATCH-1: done pulses in the next cycle, out_valid drops, FSM goes to ACCUM with in_ready=1 in that same cycle.
- Saturation: sat_W clamps to [-2^(W-1), 2^(W-1)-1]. Shifts are arithmetic and truncate toward -inf.
- in_valid while in_ready=0 is ignored; the source must hold it.
- gama/inv_std must be stable in the CALC cycle; changes elsewhere have no effect.

Test Plan:
- Uniform grad:
  - Stimulus: FRAC=8; 8 beats dy=256, xhat=0; gama=256, inv_std=256.
  - Response: dbeta=2048, dgama=0, stat_valid=1; 8 dx=0; done pulse; first out_valid 2 cycles after last in beat.
- Correlated:
  - Stimulus: dy=xhat alternating +256/-256.
  - Response: dgama=2048, dbeta=0, mean_dyx=256; all 8 dx=0.
- Impulse:
  - Stimulus: dy=[256,0×7], xhat=0, gama=512, inv_std=256.
  - Response: scale=512, mean_dy=32; dx=[448, -64×7]; dbeta=256.
- Saturation:
  - Stimulus: dy=[32767, -32768×7], xhat=0, gama=inv_std=32767.
  - Response: scale=32767, mean_dy=-24577; dx0=32767 (clamped); dx1..7 = sat((32767*(-8191))>>>8) = -32768.
- Backpressure:
  - Stimulus: impulse batch, out_ready=0 for 3 cycles while dx1 is presented.
  - Response: dx holds -64 with out_valid=1; sequence is still exactly 8 values; in_ready stays 0 until done.
- Reset mid-EMIT:
  - Stimulus: assert reset=0 after 3 dx accepted.
  - Response: immediately out_valid=0, in_ready=1, stat_valid=0, dgama=dbeta=0; a following fresh uniform batch gives the uniform-grad results.
